// File: rtl/bcd2bin_trans_pkg.sv
// Shared constants and FSM encoding for the BCD<->binary conversion blocks.
package bcd2bin_trans_pkg;

  localparam int unsigned BCD_DIGITS  = 3;
  localparam int unsigned BCD_BIN_W   = 10;
  localparam int unsigned SHIFT_STEPS = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_t;

  function automatic logic digit_ok(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd2bin_trans_digit_adj.sv
// Per-digit correction for the reverse double-dabble step.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= 4'd8) adj = digit - 4'd3;
  end

endmodule

// File: rtl/bcd2bin_trans.sv
// Sequential BCD-to-binary converter: one shift-and-correct step per clock.
module bcd2bin_trans
  import bcd2bin_trans_pkg::*;
#(
  parameter int unsigned N_DIGITS = bcd2bin_trans_pkg::BCD_DIGITS,
  parameter int unsigned BIN_W    = bcd2bin_trans_pkg::BCD_BIN_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BCD_W  = 4 * N_DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam logic [3:0]  LAST_STEP = 4'(SHIFT_STEPS - 1);

  conv_state_t       state_q;
  logic [3:0]        cnt_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] shifted;
  logic [WORK_W-1:0] work_d;
  logic              in_ok;

  assign shifted = work_q >> 1;
  assign work_d[BIN_W-1:0] = shifted[BIN_W-1:0];

  // Correction applies only to the BCD field, after the shift.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (shifted[BIN_W + 4*g +: 4]),
      .adj   (work_d[BIN_W + 4*g +: 4])
    );
  end

  always_comb begin
    in_ok = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!digit_ok(bcd_in[4*i +: 4])) in_ok = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (in_ok) begin
              work_q  <= {bcd_in, {BIN_W{1'b0}}};
              cnt_q   <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              state_q <= ST_SHIFT;
            end else begin
              // Invalid code completes immediately without entering SHIFT.
              err     <= 1'b1;
              done    <= 1'b1;
              bin_out <= '0;
            end
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          if (cnt_q == LAST_STEP) begin
            bin_out <= work_d[BIN_W-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_trans.sv
// Scoreboard bench for bcd2bin_trans against a decimal reference model.
module tb_bcd2bin_trans;

  typedef struct {
    logic [9:0] bin;
    logic       err;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [11:0] bcd_in  = '0;
  logic [9:0]  bin_out;
  logic        busy, done, err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cycle  = 0;
  exp_t        sb[$];
  int unsigned done_times[$];
  int unsigned acc_cycle;

  bcd2bin_trans #(.N_DIGITS(3), .BIN_W(10)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cycle <= cycle + 1;

  function automatic exp_t ref_model(input logic [11:0] code);
    exp_t e;
    int h, t, o;
    h = int'(code[11:8]);
    t = int'(code[7:4]);
    o = int'(code[3:0]);
    if (h > 9 || t > 9 || o > 9) begin
      e.bin = '0;
      e.err = 1'b1;
    end else begin
      e.bin = 10'(h * 100 + t * 10 + o);
      e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, watches busy length and output stability.
  int unsigned run_len = 0;
  logic        prev_busy = 1'b0;
  logic [9:0]  prev_bin  = '0;
  logic        prev_err  = 1'b0;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      run_len   = 0;
      prev_busy = 1'b0;
      check("done_in_reset", int'(done), 0);
    end else begin
      if (done) begin
        done_times.push_back(cycle);
        check("busy_at_done", int'(busy), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bin_out", int'(bin_out), int'(e.bin));
          check("err", int'(err), int'(e.err));
        end
      end
      if (busy && prev_busy) begin
        check("bin_stable_in_shift", int'(bin_out), int'(prev_bin));
        check("err_stable_in_shift", int'(err), int'(prev_err));
      end
      if (busy) run_len++;
      else if (run_len != 0) begin
        check("busy_len", int'(run_len), 10);
        run_len = 0;
      end
      prev_busy = busy;
      prev_bin  = bin_out;
      prev_err  = err;
    end
  end

  task automatic issue(input logic [11:0] code, input bit hold);
    int unsigned n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy && n < 40);
    if (busy) check("issue_timeout", 1, 0);
    start  = 1'b1;
    bcd_in = code;
    sb.push_back(ref_model(code));
    @(posedge sys_clk);
    #1;
    acc_cycle = cycle;
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    start = 1'b0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    check("drain_empty", int'(sb.size()), 0);
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check("rst_bin", int'(bin_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    sys_rst = 1'b0;

    // 999 with a single start pulse: completion ten edges after acceptance.
    done_times.delete();
    issue(12'h999, 1'b0);
    check("busy_after_e0", int'(busy), 1);
    drain();
    check("done_count_999", int'(done_times.size()), 1);
    if (done_times.size() == 1) check("latency_999", int'(done_times[0] - acc_cycle), 10);

    // Back-to-back with start held: completions 11 cycles apart.
    done_times.delete();
    issue(12'h000, 1'b1);
    issue(12'h512, 1'b1);
    issue(12'h100, 1'b1);
    drain();
    check("b2b_count", int'(done_times.size()), 3);
    if (done_times.size() == 3) begin
      check("b2b_gap1", int'(done_times[1] - done_times[0]), 11);
      check("b2b_gap2", int'(done_times[2] - done_times[1]), 11);
    end

    // Invalid digit completes at acceptance; next valid request clears err.
    issue(12'h1A0, 1'b0);
    check("inv_done", int'(done), 1);
    check("inv_err", int'(err), 1);
    check("inv_busy", int'(busy), 0);
    check("inv_bin", int'(bin_out), 0);
    issue(12'h042, 1'b0);
    check("valid_err_cleared", int'(err), 0);
    drain();
    check("bin_042", int'(bin_out), 42);

    // Requests during SHIFT are ignored.
    done_times.delete();
    issue(12'h250, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      start  = (i % 2 == 0);
      bcd_in = 12'h777;
    end
    start = 1'b0;
    drain();
    check("ignore_done_count", int'(done_times.size()), 1);
    check("bin_250", int'(bin_out), 250);

    // Asynchronous reset mid-conversion abandons it.
    done_times.delete();
    issue(12'h999, 1'b0);
    repeat (5) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    check("arst_bin", int'(bin_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_err", int'(err), 0);
    sb.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("arst_no_done", int'(done_times.size()), 0);
    issue(12'h123, 1'b0);
    drain();
    check("bin_123", int'(bin_out), 123);

    // Exhaustive valid sweep, then every code containing an invalid digit.
    for (int v = 0; v < 1000; v++) issue(to_bcd(v), 1'b1);
    drain();
    for (int c = 0; c < 4096; c++) begin
      logic [11:0] code;
      code = 12'(c);
      if (code[11:8] > 4'd9 || code[7:4] > 4'd9 || code[3:0] > 4'd9) issue(code, 1'b1);
    end
    drain();

    // Random mix with idle gaps.
    for (int i = 0; i < 200; i++) begin
      issue(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge sys_clk);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
